conv5x5_pim_sched: RTL and testbench
====================================

Name: conv5x5_pim_sched

Overview:
- Sequencing controller for one 5x5 PIM convolution unit (6-bit inputs, 6-bit result, 5-bit crossbar address, compute enable).
- Accepts one input window per handshake.
- Walks every output channel and every input-channel group stored in the crossbar: drives address and enable, waits the array's latency, and accumulates the partial results per output channel.
- Streams one accumulated result per output channel downstream under valid/ready.

Parameters:
- NUM_OCH, 4, output channels mapped in the crossbar
- NUM_ICG, 4, input-channel groups per output channel (partial sums per channel)
- PIM_LAT, 1, cycles from the issue cycle to the cycle where pim_result is valid; must be >= 1
- ADDR_W, 5, crossbar address width; NUM_OCH*NUM_ICG <= 2^ADDR_W
- RES_W, 6, PIM result width
- ACC_W, 8, accumulator/output width; must be >= RES_W
- GSEL_W, 2, feat_sel width, = max(1, clog2(NUM_ICG))

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- win_valid  in  1  upstream window available
- win_ready  out  1  controller idle, can accept a window
- feat_sel  out  GSEL_W  current input-channel group; upstream muxes the matching 25 features onto the PIM inputs
- pim_addr  out  ADDR_W  crossbar address = och*NUM_ICG + icg
- pim_en  out  1  compute enable, one-cycle pulse per issue
- pim_result  in  RES_W  PIM output, sampled PIM_LAT cycles after issue
- out_valid  out  1  accumulated result valid
- out_ready  in  1  downstream accepts
- out_data  out  ACC_W  accumulated channel result
- out_och  out  clog2(NUM_OCH) (min 1)  channel index of out_data
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse after the last channel handshake

Behaviour:
- Reset (rst high at a clk edge): state=IDLE; och=0, icg=0, acc=0, wait counter=0. Outputs pim_en, out_valid, busy and done are 0. pim_addr, feat_sel, out_data and out_och are 0. win_ready=0 while rst is high.
- Reset mid-operation aborts the current window immediately. No out_valid and no done is produced for it.
- States: IDLE, ISSUE, WAIT, EMIT.
- IDLE:
  - win_ready=1.
  - On win_valid&win_ready: go to ISSUE, with och=0, icg=0, acc=0.
- ISSUE (1 cycle):
  - pim_en=1 and pim_addr=och*NUM_ICG+icg.
  - feat_sel=icg, held stable from ISSUE through the end of WAIT.
  - Load the wait counter with PIM_LAT-1 and go to WAIT.
- WAIT (PIM_LAT cycles):
  - pim_en=0; pim_addr holds its value.
  - In the cycle where the counter is 0, sample pim_result: acc <= acc + zero-extended pim_result.
  - Then: if icg<NUM_ICG-1, set icg++ and go to ISSUE; otherwise go to EMIT.
  - The counter decrements in every other WAIT cycle.
- EMIT:
  - out_valid=1 with out_data=acc and out_och=och.
  - out_data and out_och stay stable while out_valid=1 && out_ready=0. Backpressure stalls indefinitely.
  - On handshake, if och<NUM_OCH-1: och++, icg=0, acc=0, go to ISSUE.
  - On handshake at the last channel: go to IDLE, with done=1 in the next cycle (registered).
- Window accept cannot coincide with EMIT, because win_ready is 0 outside IDLE. A new window may be accepted in the same cycle that done is high.
- Timing per channel: NUM_ICG*(1+PIM_LAT) cycles, plus the EMIT cycles.
- Defaults, with window accepted at cycle 0:
  - Issues at cycles 1, 3, 5, 7; samples at 2, 4, 6, 8.
  - First out_valid at cycle 9.
- Overflow without the optional feature: the accumulator wraps modulo 2^ACC_W.
- out_valid is never asserted while rst=1.

Optional Feature:
- Macro: CONV5X5_PIM_SCHED_SAT_EN.
- Defined: accumulation saturates. If acc + pim_result > 2^ACC_W-1, acc becomes 2^ACC_W-1 and stays there until the channel is cleared.
- Undefined: wrap-around addition modulo 2^ACC_W.

Test Plan:
- Defaults; pim_result model = pim_addr+1 (registered, latency 1); one window; out_ready=1 → out_data 10, 26, 42, 58 with out_och 0..3. pim_addr sequence 0..15; first out_valid at cycle 9; done pulses once, one cycle after the och=3 handshake.
- Same stimulus with out_ready=0 for 5 cycles at och=1 → out_valid stays high, out_data=26 stable, no further pim_en until handshake. Final results unchanged.
- PIM_LAT=3 → pim_en pulses spaced 4 cycles apart; pim_result sampled exactly 3 cycles after each issue; result values as in test 1.
- NUM_ICG=8, NUM_OCH=2, pim_result constant 63 → macro undefined: out_data=504 mod 256=248; macro defined: out_data=255 for both channels.
- rst asserted during WAIT of och=2 → next cycle state IDLE, win_ready=1, busy=0, no out_valid, no done. A new window then yields och0=10.
- win_valid held high continuously → second window accepted in the cycle after the first window's last handshake (done high), with no lost or duplicated outputs.

Source files
------------

// File: rtl/conv5x5_pim_sched.sv
// conv5x5_pim_sched: sequencing controller for one 5x5 PIM convolution unit.
// Accepts one input window per handshake, then issues every
// (output channel, input-channel group) pair stored in the crossbar, waits
// for the array latency, and accumulates the partial results per channel.
// Each accumulated channel result is streamed out under valid/ready.
// Optional feature: define CONV5X5_PIM_SCHED_SAT_EN to make the accumulator
// saturate at 2^ACC_W-1. Without it, the accumulator wraps modulo 2^ACC_W.
module conv5x5_pim_sched #(
    parameter int NUM_OCH = 4,
    parameter int NUM_ICG = 4,
    parameter int PIM_LAT = 1,
    parameter int ADDR_W  = 5,
    parameter int RES_W   = 6,
    parameter int ACC_W   = 8,
    parameter int GSEL_W  = 2,
    localparam int OCH_W  = (NUM_OCH > 1) ? $clog2(NUM_OCH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              win_valid,
    output logic              win_ready,
    output logic [GSEL_W-1:0] feat_sel,
    output logic [ADDR_W-1:0] pim_addr,
    output logic              pim_en,
    input  logic [RES_W-1:0]  pim_result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_data,
    output logic [OCH_W-1:0]  out_och,
    output logic              busy,
    output logic              done
);

    localparam int                CNT_W    = (PIM_LAT > 1) ? $clog2(PIM_LAT) : 1;
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(PIM_LAT - 1);
    localparam logic [GSEL_W-1:0] ICG_LAST = GSEL_W'(NUM_ICG - 1);
    localparam logic [OCH_W-1:0]  OCH_LAST = OCH_W'(NUM_OCH - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        EMIT
    } state_t;

    state_t           state;
    logic [OCH_W-1:0] och;
    logic [GSEL_W-1:0] icg;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_sum;
    logic [CNT_W-1:0] wait_cnt;

    // Window acceptance is only possible while idle and out of reset.
    assign win_ready = (state == IDLE) && !rst;
    assign feat_sel  = icg;
    assign out_och   = och;

    // Accumulator value after adding the zero-extended partial result.
    always_comb begin
`ifdef CONV5X5_PIM_SCHED_SAT_EN
        logic [ACC_W:0] wide_sum;
        wide_sum = {1'b0, acc} + (ACC_W + 1)'(pim_result);
        acc_sum  = wide_sum[ACC_W] ? '1 : wide_sum[ACC_W-1:0];
`else
        acc_sum = acc + ACC_W'(pim_result);
`endif
    end

    // Controller FSM: state, loop counters, accumulator and registered outputs.
    // pim_addr walks och*NUM_ICG+icg, which is contiguous, so it simply
    // increments on every issue after the first of a window.
    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            och       <= '0;
            icg       <= '0;
            acc       <= '0;
            wait_cnt  <= '0;
            pim_en    <= 1'b0;
            pim_addr  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            pim_en <= 1'b0;
            done   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (win_valid && win_ready) begin
                        state    <= ISSUE;
                        och      <= '0;
                        icg      <= '0;
                        acc      <= '0;
                        pim_en   <= 1'b1;
                        pim_addr <= '0;
                        busy     <= 1'b1;
                    end
                end
                ISSUE: begin
                    wait_cnt <= CNT_LOAD;
                    state    <= WAIT;
                end
                WAIT: begin
                    if (wait_cnt == '0) begin
                        acc <= acc_sum;
                        if (icg != ICG_LAST) begin
                            icg      <= icg + 1'b1;
                            pim_en   <= 1'b1;
                            pim_addr <= pim_addr + 1'b1;
                            state    <= ISSUE;
                        end else begin
                            out_valid <= 1'b1;
                            out_data  <= acc_sum;
                            state     <= EMIT;
                        end
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (och != OCH_LAST) begin
                            och      <= och + 1'b1;
                            icg      <= '0;
                            acc      <= '0;
                            pim_en   <= 1'b1;
                            pim_addr <= pim_addr + 1'b1;
                            state    <= ISSUE;
                        end else begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv5x5_pim_sched.sv
// tb_conv5x5_pim_sched: self-checking bench for conv5x5_pim_sched.
// Three instances: defaults, PIM_LAT=3, and NUM_OCH=2/NUM_ICG=8.
// Each instance sees a crossbar model: a table indexed by pim_addr whose
// entry appears on pim_result exactly PIM_LAT cycles after the issue,
// with random filler in every other cycle.
module tb_conv5x5_pim_sched;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    initial forever #5 clk = ~clk;

    // Default instance
    logic       d_win_valid, d_win_ready, d_pim_en, d_out_valid, d_out_ready, d_busy, d_done;
    logic [1:0] d_feat_sel, d_out_och;
    logic [4:0] d_pim_addr;
    logic [5:0] d_pim_result;
    logic [7:0] d_out_data;
    logic [5:0] d_mem [32];

    // PIM_LAT=3 instance
    logic       l_win_valid, l_win_ready, l_pim_en, l_out_valid, l_busy, l_done;
    logic [1:0] l_feat_sel, l_out_och;
    logic [4:0] l_pim_addr;
    logic [5:0] l_pim_result;
    logic [7:0] l_out_data;
    logic [5:0] l_mem [32];
    logic [5:0] l_pipe [3];

    // NUM_OCH=2, NUM_ICG=8 instance
    logic       w_win_valid, w_win_ready, w_pim_en, w_out_valid, w_busy, w_done;
    logic [2:0] w_feat_sel;
    logic [0:0] w_out_och;
    logic [4:0] w_pim_addr;
    logic [5:0] w_pim_result;
    logic [7:0] w_out_data;
    logic [5:0] w_mem [32];

    logic       r_ready = 1'b1;

    conv5x5_pim_sched u_dut (
        .clk(clk), .rst(rst), .win_valid(d_win_valid), .win_ready(d_win_ready),
        .feat_sel(d_feat_sel), .pim_addr(d_pim_addr), .pim_en(d_pim_en),
        .pim_result(d_pim_result), .out_valid(d_out_valid), .out_ready(d_out_ready),
        .out_data(d_out_data), .out_och(d_out_och), .busy(d_busy), .done(d_done)
    );

    conv5x5_pim_sched #(.PIM_LAT(3)) u_lat3 (
        .clk(clk), .rst(rst), .win_valid(l_win_valid), .win_ready(l_win_ready),
        .feat_sel(l_feat_sel), .pim_addr(l_pim_addr), .pim_en(l_pim_en),
        .pim_result(l_pim_result), .out_valid(l_out_valid), .out_ready(r_ready),
        .out_data(l_out_data), .out_och(l_out_och), .busy(l_busy), .done(l_done)
    );

    conv5x5_pim_sched #(.NUM_OCH(2), .NUM_ICG(8), .GSEL_W(3)) u_wide (
        .clk(clk), .rst(rst), .win_valid(w_win_valid), .win_ready(w_win_ready),
        .feat_sel(w_feat_sel), .pim_addr(w_pim_addr), .pim_en(w_pim_en),
        .pim_result(w_pim_result), .out_valid(w_out_valid), .out_ready(r_ready),
        .out_data(w_out_data), .out_och(w_out_och), .busy(w_busy), .done(w_done)
    );

    // Crossbar models: table lookup delayed by the array latency.
    always_ff @(posedge clk) d_pim_result <= d_pim_en ? d_mem[d_pim_addr] : 6'($urandom);
    always_ff @(posedge clk) w_pim_result <= w_pim_en ? w_mem[w_pim_addr] : 6'($urandom);
    always_ff @(posedge clk) begin
        l_pipe[0] <= l_pim_en ? l_mem[l_pim_addr] : 6'($urandom);
        l_pipe[1] <= l_pipe[0];
        l_pipe[2] <= l_pipe[1];
    end
    assign l_pim_result = l_pipe[2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs n_win windows on the default instance with win_valid held high,
    // optionally stalling one channel's output for stall_n cycles.
    task automatic run_default(input int stall_och, input int stall_n, input int n_win);
        logic [7:0] exp_sum [4];
        int         hs_och[$];
        logic [7:0] hs_dat[$];
        int         stall_left;
        int         n_done;
        logic [7:0] held;
        bit         finished;
        bit         expect_restart;
        for (int o = 0; o < 4; o++) begin
            exp_sum[o] = 8'd0;
            for (int i = 0; i < 4; i++) exp_sum[o] = 8'(exp_sum[o] + d_mem[o*4+i]);
        end
        stall_left     = stall_n;
        n_done         = 0;
        finished       = 1'b0;
        expect_restart = 1'b0;
        held           = 8'd0;
        d_out_ready    = 1'b1;
        d_win_valid    = 1'b1;
        for (int t = 0; t < 400 && !finished; t++) begin
            if (expect_restart) begin
                check("restart_pim_en", d_pim_en, 1);
                check("restart_addr", d_pim_addr, 0);
                expect_restart = 1'b0;
            end
            if (d_done) begin
                n_done++;
                if (n_done == n_win) begin
                    finished    = 1'b1;
                    d_win_valid = 1'b0;
                end else begin
                    check("restart_win_ready", d_win_ready, 1);
                    expect_restart = 1'b1;
                end
            end
            if (d_out_valid) begin
                check("emit_no_issue", d_pim_en, 0);
                if (int'(d_out_och) == stall_och && stall_left > 0) begin
                    if (stall_left == stall_n) held = d_out_data;
                    else check("stall_data_stable", d_out_data, held);
                    d_out_ready = 1'b0;
                    stall_left--;
                end else begin
                    d_out_ready = 1'b1;
                    hs_och.push_back(int'(d_out_och));
                    hs_dat.push_back(d_out_data);
                end
            end
            if (!finished) step();
        end
        d_out_ready = 1'b1;
        check("run_finished", finished, 1);
        check("hs_count", hs_och.size(), 4 * n_win);
        for (int j = 0; j < hs_och.size(); j++) begin
            check("hs_och", hs_och[j], j % 4);
            check("hs_data", hs_dat[j], exp_sum[j % 4]);
        end
        step();
        check("done_single_pulse", d_done, 0);
    endtask

    int         iss_cyc[$];
    int         iss_adr[$];
    int         iss_sel[$];
    int         out_dat[$];
    int         out_chn[$];
    bit         found;
    bit         fin;
    int         exp_w [2];

    initial begin
        rst         = 1'b1;
        d_win_valid = 1'b0;
        d_out_ready = 1'b1;
        l_win_valid = 1'b0;
        w_win_valid = 1'b0;
        for (int i = 0; i < 32; i++) begin
            d_mem[i] = 6'(i + 1);
            l_mem[i] = 6'(i + 1);
        end
        repeat (3) step();

        // Reset state
        check("rst_win_ready", d_win_ready, 0);
        check("rst_pim_en", d_pim_en, 0);
        check("rst_out_valid", d_out_valid, 0);
        check("rst_busy", d_busy, 0);
        check("rst_done", d_done, 0);
        check("rst_pim_addr", d_pim_addr, 0);
        check("rst_feat_sel", d_feat_sel, 0);
        check("rst_out_data", d_out_data, 0);
        check("rst_out_och", d_out_och, 0);
        rst = 1'b0;
        #1;
        check("idle_win_ready", d_win_ready, 1);

        // Cycle-exact schedule, table = addr+1, out_ready=1; accept in cycle 0.
        d_win_valid = 1'b1;
        step();
        d_win_valid = 1'b0;
        for (int c = 1; c <= 37; c++) begin
            int         ch;
            int         k;
            logic [7:0] s;
            ch = (c - 1) / 9;
            k  = (c - 1) % 9;
            if (c == 37) begin
                check("t1_done", d_done, 1);
                check("t1_end_valid", d_out_valid, 0);
                check("t1_end_busy", d_busy, 0);
                check("t1_end_ready", d_win_ready, 1);
            end else begin
                check("t1_pim_en", d_pim_en, 32'(k < 8 && k % 2 == 0));
                check("t1_busy", d_busy, 1);
                check("t1_no_done", d_done, 0);
                if (k < 8) begin
                    check("t1_addr", d_pim_addr, ch * 4 + k / 2);
                    check("t1_feat_sel", d_feat_sel, k / 2);
                    check("t1_no_valid", d_out_valid, 0);
                end else begin
                    s = 8'd0;
                    for (int i = 0; i < 4; i++) s = 8'(s + d_mem[ch*4+i]);
                    check("t1_valid", d_out_valid, 1);
                    check("t1_data", d_out_data, s);
                    check("t1_och", d_out_och, ch);
                end
            end
            step();
        end
        check("t1_done_once", d_done, 0);

        // Backpressure at och=1 for 5 cycles, random crossbar contents.
        for (int i = 0; i < 32; i++) d_mem[i] = 6'($urandom);
        run_default(1, 5, 1);

        // Random stall position and length.
        for (int i = 0; i < 32; i++) d_mem[i] = 6'($urandom);
        run_default(int'($urandom_range(0, 3)), int'($urandom_range(1, 6)), 1);

        // win_valid held high across two back-to-back windows.
        for (int i = 0; i < 32; i++) d_mem[i] = 6'($urandom);
        run_default(-1, 0, 2);

        // Reset during WAIT of och=2.
        for (int i = 0; i < 32; i++) d_mem[i] = 6'(i + 1);
        d_win_valid = 1'b1;
        step();
        d_win_valid = 1'b0;
        found = 1'b0;
        for (int t = 0; t < 100 && !found; t++) begin
            if (d_pim_en && d_pim_addr == 5'd8) found = 1'b1;
            else step();
        end
        check("rst_found_och2", found, 1);
        step();
        check("rst_in_wait_busy", d_busy, 1);
        rst = 1'b1;
        #1;
        check("rst_win_ready_low", d_win_ready, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("rst_abort_ready", d_win_ready, 1);
        check("rst_abort_busy", d_busy, 0);
        check("rst_abort_valid", d_out_valid, 0);
        check("rst_abort_done", d_done, 0);
        check("rst_abort_pim_en", d_pim_en, 0);
        for (int t = 0; t < 10; t++) begin
            step();
            check("rst_quiet_valid", d_out_valid, 0);
            check("rst_quiet_done", d_done, 0);
        end
        run_default(-1, 0, 1);

        // PIM_LAT=3: issue spacing and exact sampling cycle.
        l_win_valid = 1'b1;
        step();
        l_win_valid = 1'b0;
        fin = 1'b0;
        for (int t = 0; t < 300 && !fin; t++) begin
            if (l_pim_en) begin
                iss_cyc.push_back(t);
                iss_adr.push_back(int'(l_pim_addr));
                iss_sel.push_back(int'(l_feat_sel));
            end
            if (l_out_valid) begin
                out_dat.push_back(int'(l_out_data));
                out_chn.push_back(int'(l_out_och));
            end
            if (l_done) fin = 1'b1;
            step();
        end
        check("l3_finished", fin, 1);
        check("l3_issues", iss_cyc.size(), 16);
        for (int i = 0; i < iss_cyc.size(); i++) begin
            check("l3_addr", iss_adr[i], i);
            check("l3_feat_sel", iss_sel[i], i % 4);
            if (i % 4 != 0) check("l3_spacing", iss_cyc[i] - iss_cyc[i-1], 4);
        end
        check("l3_outputs", out_dat.size(), 4);
        for (int o = 0; o < out_dat.size(); o++) begin
            check("l3_data", out_dat[o], 16 * o + 10);
            check("l3_och", out_chn[o], o);
        end

        // NUM_OCH=2, NUM_ICG=8: och0 all 63, och1 random.
        for (int i = 0; i < 32; i++) w_mem[i] = (i < 8) ? 6'd63 : 6'($urandom);
        for (int o = 0; o < 2; o++) begin
            int s;
            s = 0;
            for (int i = 0; i < 8; i++) s += int'(w_mem[o*8+i]);
`ifdef CONV5X5_PIM_SCHED_SAT_EN
            exp_w[o] = (s > 255) ? 255 : s;
`else
            exp_w[o] = s % 256;
`endif
        end
        iss_adr.delete();
        iss_sel.delete();
        out_dat.delete();
        out_chn.delete();
        w_win_valid = 1'b1;
        step();
        w_win_valid = 1'b0;
        fin = 1'b0;
        for (int t = 0; t < 300 && !fin; t++) begin
            if (w_pim_en) begin
                iss_adr.push_back(int'(w_pim_addr));
                iss_sel.push_back(int'(w_feat_sel));
            end
            if (w_out_valid) begin
                out_dat.push_back(int'(w_out_data));
                out_chn.push_back(int'(w_out_och));
            end
            if (w_done) fin = 1'b1;
            step();
        end
        check("wide_finished", fin, 1);
        check("wide_issues", iss_adr.size(), 16);
        for (int i = 0; i < iss_adr.size(); i++) begin
            check("wide_addr", iss_adr[i], i);
            check("wide_feat_sel", iss_sel[i], i % 8);
        end
        check("wide_outputs", out_dat.size(), 2);
        for (int o = 0; o < out_dat.size(); o++) begin
            check("wide_data", out_dat[o], exp_w[o]);
            check("wide_och", out_chn[o], o);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
